conv3x3_window: RTL and testbench

//  3x3 stencil convolution consuming the three row taps of the line-buffer chain:
//  tap0 = live pixel, tap1/tap2 = outputs of one/two WIDTH-deep line shift registers.

---
 rtl/conv3x3_window.sv | 211 +++++++++++++++++++++
 tb/tb_conv3x3_window.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_window.sv
// rtl/conv3x3_window.sv - 3x3 stencil convolution over three line-buffer row taps
// Builds the window from the taps, tracks frame position and emits one pixel per interior window.
module conv3x3_window #(
    parameter int unsigned WIDTH  = 640,
    parameter int unsigned HEIGHT = 480,
    parameter logic [71:0] KERNEL = 72'hFF_FF_FF_FF_08_FF_FF_FF_FF,
    parameter int unsigned SHIFT  = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               sof,
    input  logic signed [16:0] tap0,
    input  logic signed [16:0] tap1,
    input  logic signed [16:0] tap2,
    output logic               out_valid,
    output logic signed [16:0] out_pixel,
    output logic               out_sat,
    output logic               out_eof,
    output logic [15:0]        out_x,
    output logic [15:0]        out_y
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    localparam logic [15:0] LAST_X = 16'(WIDTH - 1);
    localparam logic [15:0] LAST_Y = 16'(HEIGHT - 1);
    localparam logic [15:0] EOF_X  = 16'(WIDTH - 2);
    localparam logic [15:0] EOF_Y  = 16'(HEIGHT - 2);
    localparam logic signed [29:0] ROUND   = (30'sd1 <<< SHIFT) >>> 1;
    localparam logic signed [29:0] SAT_MAX = 30'sd65535;
    localparam logic signed [29:0] SAT_MIN = -30'sd65536;

    state_t r_state;
    state_t w_state_nxt;

    logic [15:0] r_col;
    logic [15:0] r_row;
    logic        w_accept;
    logic        w_at_last;
    logic        w_restart;
    logic [15:0] w_px;
    logic [15:0] w_py;
    logic [15:0] w_col_nxt;
    logic [15:0] w_row_nxt;

    logic [2:0][2:0][16:0] r_win;
    logic                  r_wv;
    logic [15:0]           r_wx;
    logic [15:0]           r_wy;

    logic [8:0][24:0] w_prod;
    logic [8:0][24:0] r_prod;
    logic             r_v1;
    logic [15:0]      r_x1;
    logic [15:0]      r_y1;

    logic signed [28:0] w_sum;
    logic signed [28:0] r_sum;
    logic               r_v2;
    logic [15:0]        r_x2;
    logic [15:0]        r_y2;

    logic signed [29:0] w_rnd;
    logic signed [16:0] w_pix;
    logic               w_sat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid && sof) w_state_nxt = S_RUN;
            S_RUN:   if (in_valid && w_at_last && !sof) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A sof landing exactly on the last pixel keeps that pixel's position so its window still fires.
    always_comb begin
        w_at_last = (r_state == S_RUN) && (r_col == LAST_X) && (r_row == LAST_Y);
        w_accept  = in_valid && ((r_state == S_RUN) || sof);
        w_restart = sof && !w_at_last;
    end

    always_comb begin
        w_px      = w_restart ? 16'd0 : r_col;
        w_py      = w_restart ? 16'd0 : r_row;
        w_col_nxt = w_px + 16'd1;
        w_row_nxt = w_py;
        if (w_px == LAST_X) begin
            w_col_nxt = 16'd0;
            w_row_nxt = (w_py == LAST_Y) ? 16'd0 : w_py + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= 16'd0;
            r_row <= 16'd0;
        end else if (w_accept) begin
            r_col <= w_col_nxt;
            r_row <= w_row_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_win <= '0;
            r_wv  <= 1'b0;
            r_wx  <= 16'd0;
            r_wy  <= 16'd0;
        end else begin
            r_wv <= w_accept && (w_px >= 16'd2) && (w_py >= 16'd2);
            if (w_accept) begin
                for (int i = 0; i < 3; i++) begin
                    r_win[i][0] <= r_win[i][1];
                    r_win[i][1] <= r_win[i][2];
                end
                r_win[0][2] <= tap2;
                r_win[1][2] <= tap1;
                r_win[2][2] <= tap0;
                r_wx        <= w_px - 16'd1;
                r_wy        <= w_py - 16'd1;
            end
        end
    end

    always_comb begin
        w_prod = '0;
        for (int k = 0; k < 9; k++) begin
            w_prod[k] = 25'($signed(r_win[k / 3][k % 3])) * 25'($signed(KERNEL[8 * k +: 8]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prod <= '0;
            r_v1   <= 1'b0;
            r_x1   <= 16'd0;
            r_y1   <= 16'd0;
        end else begin
            r_prod <= w_prod;
            r_v1   <= r_wv;
            r_x1   <= r_wx;
            r_y1   <= r_wy;
        end
    end

    always_comb begin
        w_sum = '0;
        for (int k = 0; k < 9; k++) begin
            w_sum = w_sum + 29'($signed(r_prod[k]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum <= '0;
            r_v2  <= 1'b0;
            r_x2  <= 16'd0;
            r_y2  <= 16'd0;
        end else begin
            r_sum <= w_sum;
            r_v2  <= r_v1;
            r_x2  <= r_x1;
            r_y2  <= r_y1;
        end
    end

    // ROUND is zero when SHIFT is zero, so one path covers both cases.
    always_comb begin
        w_rnd = (30'(r_sum) + ROUND) >>> SHIFT;
        w_pix = w_rnd[16:0];
        w_sat = 1'b0;
        if (w_rnd > SAT_MAX) begin
            w_pix = 17'sd65535;
            w_sat = 1'b1;
        end else if (w_rnd < SAT_MIN) begin
            w_pix = -17'sd65536;
            w_sat = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_pixel <= '0;
            out_sat   <= 1'b0;
            out_eof   <= 1'b0;
            out_x     <= 16'd0;
            out_y     <= 16'd0;
        end else begin
            out_valid <= r_v2;
            out_eof   <= r_v2 && (r_x2 == EOF_X) && (r_y2 == EOF_Y);
            if (r_v2) begin
                out_pixel <= w_pix;
                out_sat   <= w_sat;
                out_x     <= r_x2;
                out_y     <= r_y2;
            end
        end
    end

endmodule

// File: tb/tb_conv3x3_window.sv
// tb/tb_conv3x3_window.sv - scoreboard bench for conv3x3_window
`timescale 1ns/1ps
module tb_conv3x3_window;

    localparam int W = 8;
    localparam int H = 6;
    localparam logic [71:0] K_DEF = 72'hFF_FF_FF_FF_08_FF_FF_FF_FF;
    localparam logic [71:0] K_ONE = {9{8'h01}};

    typedef struct {
        int       px0;
        int       px1;
        int       px2;
        bit [2:0] sat;
        int       x;
        int       y;
        bit       eof;
        int       cyc;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               sof = 1'b0;
    logic signed [16:0] tap0 = '0;
    logic signed [16:0] tap1 = '0;
    logic signed [16:0] tap2 = '0;

    logic               o_v   [3];
    logic signed [16:0] o_px  [3];
    logic               o_sat [3];
    logic               o_eof [3];
    logic [15:0]        o_x   [3];
    logic [15:0]        o_y   [3];

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   n_out   = 0;
    int   n_eof   = 0;
    exp_t sb[$];
    exp_t m_e;

    bit m_run = 1'b0;
    int m_col = 0;
    int m_row = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv3x3_window #(.WIDTH(W), .HEIGHT(H), .KERNEL(K_DEF), .SHIFT(0)) u_def (
        .clk(clk), .rst(rst), .in_valid(in_valid), .sof(sof),
        .tap0(tap0), .tap1(tap1), .tap2(tap2),
        .out_valid(o_v[0]), .out_pixel(o_px[0]), .out_sat(o_sat[0]), .out_eof(o_eof[0]),
        .out_x(o_x[0]), .out_y(o_y[0])
    );

    conv3x3_window #(.WIDTH(W), .HEIGHT(H), .KERNEL(K_ONE), .SHIFT(0)) u_one (
        .clk(clk), .rst(rst), .in_valid(in_valid), .sof(sof),
        .tap0(tap0), .tap1(tap1), .tap2(tap2),
        .out_valid(o_v[1]), .out_pixel(o_px[1]), .out_sat(o_sat[1]), .out_eof(o_eof[1]),
        .out_x(o_x[1]), .out_y(o_y[1])
    );

    conv3x3_window #(.WIDTH(W), .HEIGHT(H), .KERNEL(K_ONE), .SHIFT(3)) u_shr (
        .clk(clk), .rst(rst), .in_valid(in_valid), .sof(sof),
        .tap0(tap0), .tap1(tap1), .tap2(tap2),
        .out_valid(o_v[2]), .out_pixel(o_px[2]), .out_sat(o_sat[2]), .out_eof(o_eof[2]),
        .out_x(o_x[2]), .out_y(o_y[2])
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // mode 0: constant cval everywhere; mode 1: 1000 at (3,3), zero elsewhere
    function automatic int pix(input int mode, input int cval, input int x, input int y);
        if (x < 0 || y < 0) return 0;
        if (mode == 0) return cval;
        return (x == 3 && y == 3) ? 1000 : 0;
    endfunction

    function automatic int conv(input logic [71:0] k, input int sh, input int mode, input int cval,
                                input int x, input int y, output bit sat);
        longint     s;
        longint     r;
        logic [7:0] c;
        s = 0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                c = k[8 * (3 * i + j) +: 8];
                s += longint'($signed(c)) * longint'(pix(mode, cval, x - 2 + j, y - 2 + i));
            end
        end
        r   = (sh > 0) ? ((s + (longint'(1) <<< (sh - 1))) >>> sh) : s;
        sat = 1'b0;
        if (r > 65535) begin r = 65535; sat = 1'b1; end
        if (r < -65536) begin r = -65536; sat = 1'b1; end
        return int'(r);
    endfunction

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        sof      = $urandom_range(0, 1);
        tap0     = 17'($urandom);
        tap1     = 17'($urandom);
        tap2     = 17'($urandom);
    endtask

    task automatic drive(input bit v, input bit s, input int mode, input int cval);
        bit   acc;
        bit   st;
        int   x;
        int   y;
        exp_t e;
        acc = v && (m_run || s);
        x   = m_col;
        y   = m_row;
        if (acc && s && !(m_run && m_col == W - 1 && m_row == H - 1)) begin
            x = 0;
            y = 0;
        end
        @(negedge clk);
        in_valid = v;
        sof      = s;
        if (acc) begin
            tap0 = 17'(pix(mode, cval, x, y));
            tap1 = 17'(pix(mode, cval, x, y - 1));
            tap2 = 17'(pix(mode, cval, x, y - 2));
            if (x >= 2 && y >= 2) begin
                e.px0    = conv(K_DEF, 0, mode, cval, x, y, st); e.sat[0] = st;
                e.px1    = conv(K_ONE, 0, mode, cval, x, y, st); e.sat[1] = st;
                e.px2    = conv(K_ONE, 3, mode, cval, x, y, st); e.sat[2] = st;
                e.x      = x - 1;
                e.y      = y - 1;
                e.eof    = (x - 1 == W - 2) && (y - 1 == H - 2);
                e.cyc    = cyc + 4;
                sb.push_back(e);
            end
            m_run = !(x == W - 1 && y == H - 1 && !s);
            if (x == W - 1) begin
                m_col = 0;
                m_row = (y == H - 1) ? 0 : y + 1;
            end else begin
                m_col = x + 1;
                m_row = y;
            end
        end else begin
            tap0 = 17'($urandom);
            tap1 = 17'($urandom);
            tap2 = 17'($urandom);
        end
    endtask

    task automatic frame(input int mode, input int cval, input int gap_pct);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                while ($urandom_range(0, 99) < gap_pct) idle();
                drive(1'b1, (x == 0 && y == 0), mode, cval);
            end
        end
        idle();
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while (sb.size() != 0 && t < 50) begin
            idle();
            t++;
        end
        repeat (4) idle();
        chk(tag, sb.size(), 0);
    endtask

    task automatic run_frame(input string tag, input int mode, input int cval, input int gap_pct);
        n_out = 0;
        n_eof = 0;
        frame(mode, cval, gap_pct);
        drain({tag, "_drain"});
        chk({tag, "_count"}, n_out, (W - 2) * (H - 2));
        chk({tag, "_eofs"}, n_eof, 1);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (o_eof[0]) n_eof++;
            if (o_v[0] || o_v[1] || o_v[2]) begin
                n_out++;
                if (sb.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    m_e = sb.pop_front();
                    chk("valid_def", o_v[0], 1);
                    chk("valid_one", o_v[1], 1);
                    chk("valid_shr", o_v[2], 1);
                    chk("latency", cyc, m_e.cyc);
                    chk("out_x", o_x[0], m_e.x);
                    chk("out_y", o_y[0], m_e.y);
                    chk("out_eof", o_eof[0], m_e.eof);
                    chk("px_def", o_px[0], m_e.px0);
                    chk("px_one", o_px[1], m_e.px1);
                    chk("px_shr", o_px[2], m_e.px2);
                    chk("sat_def", o_sat[0], m_e.sat[0]);
                    chk("sat_one", o_sat[1], m_e.sat[1]);
                    chk("sat_shr", o_sat[2], m_e.sat[2]);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached with %0d pending", sb.size());
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_valid", o_v[0], 0);
        chk("rst_pixel", o_px[0], 0);
        chk("rst_sat", o_sat[0], 0);
        chk("rst_eof", o_eof[0], 0);
        chk("rst_x", o_x[0], 0);
        chk("rst_y", o_y[0], 0);

        n_out = 0;
        repeat (12) drive(1'b1, 1'b0, 0, 7);
        repeat (6) idle();
        chk("idle_drop", n_out, 0);

        run_frame("t1_const100", 0, 100, 0);
        run_frame("t2_impulse", 1, 0, 0);
        run_frame("t3_pos_sat", 0, 65535, 0);
        run_frame("t3_neg_sat", 0, -65536, 0);
        run_frame("t4_one", 0, 1, 0);
        run_frame("t4_minus1", 0, -1, 0);
        run_frame("t4_four", 0, 4, 0);
        run_frame("t5_const_gap", 0, 100, 30);
        run_frame("t5_impulse_gap", 1, 0, 30);

        n_out = 0;
        for (int i = 0; i < 20; i++) drive(1'b1, (i == 0), 0, 100);
        frame(1, 0, 0);
        drain("t6_restart_drain");
        chk("t6_restart_count", n_out, 2 + (W - 2) * (H - 2));

        n_out = 0;
        n_eof = 0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                drive(1'b1, (x == 0 && y == 0) || (x == W - 1 && y == H - 1), 1, 0);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                drive(1'b1, 1'b0, 0, 3);
        drain("sof_last_drain");
        chk("sof_last_count", n_out, 2 * (W - 2) * (H - 2));
        chk("sof_last_eofs", n_eof, 2);

        for (int i = 0; i < 25; i++) drive(1'b1, (i == 0), 0, 100);
        @(negedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        sof      = 1'b0;
        sb.delete();
        m_run = 1'b0;
        m_col = 0;
        m_row = 0;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_valid_def", o_v[0], 0);
        chk("rst_mid_valid_one", o_v[1], 0);
        chk("rst_mid_valid_shr", o_v[2], 0);
        run_frame("t6_after_rst", 0, 100, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
